// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet TX frame scheduler.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    FCS,
    IFG
  } state_type;

  typedef enum logic [1:0] {
    SRC_ARP  = 2'd0,
    SRC_ICMP = 2'd1,
    SRC_UDP  = 2'd2
  } src_type;

  localparam int IFG_CYCLES_DEF  = 12;
  localparam int MAX_PAYLOAD_DEF = 1518;

  // Bit order of every 3-bit source vector: [0]=ARP, [1]=ICMP, [2]=UDP.
  function automatic src_type onehot_to_src(input logic [2:0] oh);
    case (oh)
      3'b010:  return SRC_ICMP;
      3'b100:  return SRC_UDP;
      default: return SRC_ARP;
    endcase
  endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Source, preamble, FCS and MAC TX signals of the frame scheduler.
// Handshake: a source holds its req level until its grant; while payload_en is high the granted source presents one new byte per cycle and flags the last one with its done.
interface eth_tx_scheduler_if;
  import eth_tx_pkg::*;

  logic       arp_req,  icmp_req,  udp_req;
  logic       arp_grant, icmp_grant, udp_grant;
  logic [7:0] arp_data, icmp_data, udp_data;
  logic       arp_data_done, icmp_data_done, udp_data_done;
  logic       payload_en;
  logic       preamble_start;
  logic [7:0] preamble_data;
  logic       preamble_sfd_tx_done;
  logic [7:0] fcs_payload_data;
  logic       fcs_payload_done;
  logic [7:0] fcs_data;
  logic       fcs_tx_done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_abort;
  logic       busy;
  state_type  state_dbg;

  modport master (
    input  arp_req, icmp_req, udp_req,
    input  arp_data, icmp_data, udp_data,
    input  arp_data_done, icmp_data_done, udp_data_done,
    input  preamble_data, preamble_sfd_tx_done, fcs_data, fcs_tx_done,
    output arp_grant, icmp_grant, udp_grant,
    output payload_en, preamble_start, fcs_payload_data, fcs_payload_done,
    output tx_data, tx_valid, tx_abort, busy, state_dbg
  );

  modport slave (
    output arp_req, icmp_req, udp_req,
    output arp_data, icmp_data, udp_data,
    output arp_data_done, icmp_data_done, udp_data_done,
    output preamble_data, preamble_sfd_tx_done, fcs_data, fcs_tx_done,
    input  arp_grant, icmp_grant, udp_grant,
    input  payload_en, preamble_start, fcs_payload_data, fcs_payload_done,
    input  tx_data, tx_valid, tx_abort, busy, state_dbg
  );

endinterface

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick; the search starts at the source after last.
module rr_arbiter3
  import eth_tx_pkg::*;
(
  input  logic [2:0] req,
  input  src_type    last,
  output logic [2:0] win,
  output logic       valid
);

  always_comb begin
    win = 3'b000;
    case (last)
      SRC_ARP: begin
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      SRC_ICMP: begin
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/eth_tx_scheduler.sv
// Frame-level TX controller: round-robin source arbitration, then preamble,
// payload, FCS and inter-frame gap sequencing onto the MAC byte stream.
module eth_tx_scheduler
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYCLES  = IFG_CYCLES_DEF,
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input  logic               aclk,
  input  logic               aresetn,
  eth_tx_scheduler_if.master bus
);

  localparam logic [15:0] WD_LAST  = 16'(MAX_PAYLOAD - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_type   state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  src_type     ptr_q, ptr_d;
  logic        pstart_q, pstart_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] ifg_q, ifg_d;

  logic [2:0]  req;
  logic [2:0]  win;
  logic        win_valid;
  logic [7:0]  src_data;
  logic        src_done;
  logic        abort;
  logic [7:0]  tx_data_w;
  logic        tx_valid_w;

  assign req = {bus.udp_req, bus.icmp_req, bus.arp_req};

  rr_arbiter3 u_arb (
    .req   (req),
    .last  (ptr_q),
    .win   (win),
    .valid (win_valid)
  );

  // Only the granted source can reach the payload path.
  assign src_data = ({8{grant_q[0]}} & bus.arp_data)
                  | ({8{grant_q[1]}} & bus.icmp_data)
                  | ({8{grant_q[2]}} & bus.udp_data);
  assign src_done = |(grant_q & {bus.udp_data_done, bus.icmp_data_done, bus.arp_data_done});

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= 3'b000;
      ptr_q    <= SRC_UDP;
      pstart_q <= 1'b0;
      wd_q     <= 16'd0;
      ifg_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      pstart_q <= pstart_d;
      wd_q     <= wd_d;
      ifg_q    <= ifg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    pstart_d = 1'b0;
    wd_d     = wd_q;
    ifg_d    = ifg_q;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = PREAMBLE;
          grant_d  = win;
          ptr_d    = onehot_to_src(win);
          pstart_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (bus.preamble_sfd_tx_done) begin
          state_d = PAYLOAD;
          wd_d    = 16'd0;
        end
      end
      PAYLOAD: begin
        wd_d = wd_q + 16'd1;
        if (src_done) begin
          state_d = FCS;
          grant_d = 3'b000;
        end else if (wd_q == WD_LAST) begin
          // Watchdog: drop the frame without FCS and still serve the gap.
          abort   = 1'b1;
          grant_d = 3'b000;
          state_d = IFG;
          ifg_d   = 16'd0;
        end
      end
      FCS: begin
        if (bus.fcs_tx_done) begin
          state_d = IFG;
          ifg_d   = 16'd0;
        end
      end
      IFG: begin
        ifg_d = ifg_q + 16'd1;
        if (ifg_q == IFG_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_w  = 8'h00;
    tx_valid_w = 1'b0;
    case (state_q)
      PREAMBLE: begin
        tx_data_w  = bus.preamble_data;
        tx_valid_w = 1'b1;
      end
      PAYLOAD: begin
        tx_data_w  = src_data;
        tx_valid_w = 1'b1;
      end
      FCS: begin
        tx_data_w  = bus.fcs_data;
        tx_valid_w = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.arp_grant        = grant_q[0];
  assign bus.icmp_grant       = grant_q[1];
  assign bus.udp_grant        = grant_q[2];
  assign bus.payload_en       = (state_q == PAYLOAD);
  assign bus.preamble_start   = pstart_q;
  assign bus.fcs_payload_data = (state_q == PAYLOAD) ? src_data : 8'h00;
  assign bus.fcs_payload_done = src_done & (state_q == PAYLOAD);
  assign bus.tx_data          = tx_data_w;
  assign bus.tx_valid         = tx_valid_w;
  assign bus.tx_abort         = abort;
  assign bus.busy             = (state_q != IDLE);
  assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Bench for eth_tx_scheduler: behavioural sources, preamble and FCS generators
// around the DUT, with a frame-level round-robin model feeding the scoreboard.
module tb_eth_tx_scheduler;
  import eth_tx_pkg::*;

  localparam int IFG     = 12;
  localparam int MAXP    = 64;
  localparam int PRE_LEN = 8;
  localparam int LIMIT   = 6000;

  typedef struct {
    int src;
    int nsent;
    bit abort;
    int gap;
  } frame_t;

  // clock / reset
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  eth_tx_scheduler_if bus();

  eth_tx_scheduler #(.IFG_CYCLES(IFG), .MAX_PAYLOAD(MAXP)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // source side state (consumed by the driver)
  logic [7:0] byte_q[3][$];
  int         len_q[3][$];
  int         bidx[3];
  // independent copy for the reference model
  logic [7:0] m_bytes[3][$];
  int         m_len[3][$];
  int         m_ptr = 2;

  // scoreboard
  logic [7:0] exp_q[$];
  frame_t     fr_q[$];

  logic [7:0] fcs_tab[4];
  int pre_k = -1;
  int fcs_k = -1;
  logic [2:0] s_grant;
  bit s_pe, s_abort, s_fdone;

  bit mon_en = 1'b0;
  logic [2:0] p_grant;
  bit p_valid, p_busy, have_cur;
  int gcnt, pcnt, lowrun, ifgcnt;
  frame_t cur;

  task automatic add_frame(input int s, input int len, input bit ramp);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = ramp ? 8'(i + 1) : 8'($urandom_range(0, 255));
      byte_q[s].push_back(b);
      m_bytes[s].push_back(b);
    end
    len_q[s].push_back(len);
    m_len[s].push_back(len);
  endtask

  // Frame order from pending counts and the last winner; byte stream per frame.
  task automatic build_model();
    int pc[3];
    int s, len, nsent;
    bit first, ab;
    logic [7:0] b;
    frame_t f;
    first = 1'b1;
    for (int k = 0; k < 3; k++) pc[k] = m_len[k].size();
    while (pc[0] + pc[1] + pc[2] > 0) begin
      s = 0;
      for (int k = 1; k <= 3; k++) begin
        s = (m_ptr + k) % 3;
        if (pc[s] > 0) break;
      end
      m_ptr = s;
      pc[s]--;
      len   = m_len[s].pop_front();
      ab    = (len > MAXP);
      nsent = ab ? MAXP : len;
      f.src = s; f.nsent = nsent; f.abort = ab; f.gap = first ? -1 : IFG + 1;
      fr_q.push_back(f);
      first = 1'b0;
      for (int i = 0; i < PRE_LEN; i++) exp_q.push_back((i == PRE_LEN - 1) ? 8'hD5 : 8'h55);
      for (int i = 0; i < len; i++) begin
        b = m_bytes[s].pop_front();
        if (i < nsent) exp_q.push_back(b);
      end
      if (!ab) for (int i = 0; i < 4; i++) exp_q.push_back(fcs_tab[i]);
    end
  endtask

  task automatic drive_src(input int s, input logic r, input logic [7:0] d, input logic dn);
    case (s)
      0:       begin bus.arp_req  = r; bus.arp_data  = d; bus.arp_data_done  = dn; end
      1:       begin bus.icmp_req = r; bus.icmp_data = d; bus.icmp_data_done = dn; end
      default: begin bus.udp_req  = r; bus.udp_data  = d; bus.udp_data_done  = dn; end
    endcase
  endtask

  // driver: runs just after each rising edge
  task automatic driver();
    int g;
    logic [2:0] gnow;
    g = -1;
    for (int s = 0; s < 3; s++) if (s_grant[s]) g = s;
    if (s_pe && g >= 0 && len_q[g].size() > 0) begin
      if (s_abort) begin
        repeat (len_q[g][0] - bidx[g]) byte_q[g].delete(0);
        len_q[g].delete(0);
        bidx[g] = 0;
      end else if (bidx[g] == len_q[g][0] - 1) begin
        byte_q[g].delete(0);
        len_q[g].delete(0);
        bidx[g] = 0;
      end else begin
        byte_q[g].delete(0);
        bidx[g]++;
      end
    end
    if (bus.preamble_start) pre_k = 0;
    else if (pre_k >= 0) pre_k = (pre_k == PRE_LEN - 1) ? -1 : pre_k + 1;
    if (s_fdone) fcs_k = 0;
    else if (fcs_k >= 0) fcs_k = (fcs_k == 3) ? -1 : fcs_k + 1;
    bus.preamble_data        = (pre_k < 0) ? 8'($urandom) : ((pre_k == PRE_LEN - 1) ? 8'hD5 : 8'h55);
    bus.preamble_sfd_tx_done = (pre_k < 0) ? 1'($urandom) : (pre_k == PRE_LEN - 1);
    bus.fcs_data             = (fcs_k < 0) ? 8'($urandom) : fcs_tab[fcs_k];
    bus.fcs_tx_done          = (fcs_k < 0) ? 1'($urandom) : (fcs_k == 3);
    gnow = {bus.udp_grant, bus.icmp_grant, bus.arp_grant};
    for (int s = 0; s < 3; s++) begin
      if (gnow[s] && len_q[s].size() > 0)
        drive_src(s, 1'b1, byte_q[s][0], bidx[s] == len_q[s][0] - 1);
      else
        drive_src(s, len_q[s].size() > 0, 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic sample();
    s_grant = {bus.udp_grant, bus.icmp_grant, bus.arp_grant};
    s_pe    = bus.payload_en;
    s_abort = bus.tx_abort;
    s_fdone = bus.fcs_payload_done;
  endtask

  task automatic monitor();
    bit rise;
    logic [7:0] e;
    rise = (s_grant != 3'b000) && (p_grant == 3'b000);
    check("grant_onehot", $onehot0(s_grant), 1);
    check("preamble_start", bus.preamble_start, rise);
    if (rise) begin
      if (fr_q.size() == 0) begin
        check("grant_extra", s_grant, 0);
        have_cur = 1'b0;
      end else begin
        cur = fr_q.pop_front();
        have_cur = 1'b1;
        check("grant_src", s_grant, 32'd1 << cur.src);
      end
      gcnt = 0;
      pcnt = 0;
    end
    if (s_grant != 3'b000) gcnt++;
    if (s_grant == 3'b000 && p_grant != 3'b000 && have_cur)
      check("grant_len", gcnt, PRE_LEN + cur.nsent);
    if (bus.payload_en) pcnt++;
    check("tx_abort", bus.tx_abort, bus.payload_en && have_cur && cur.abort && pcnt == MAXP);
    if (!bus.payload_en) begin
      check("fcs_pdata_zero", bus.fcs_payload_data, 0);
      check("fcs_pdone_zero", bus.fcs_payload_done, 0);
    end
    if (bus.tx_valid) begin
      if (!p_valid && have_cur && cur.gap >= 0) check("ifg_gap", lowrun, cur.gap);
      lowrun = 0;
      ifgcnt = 0;
      if (exp_q.size() == 0) check("tx_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("tx_data", bus.tx_data, e);
        if (bus.payload_en && have_cur) begin
          check("fcs_pdata", bus.fcs_payload_data, e);
          check("fcs_pdone", bus.fcs_payload_done, !cur.abort && pcnt == cur.nsent);
        end
      end
    end else begin
      lowrun++;
      check("tx_data_idle", bus.tx_data, 0);
      if (bus.busy) ifgcnt++;
    end
    if (p_busy && !bus.busy) check("ifg_len", ifgcnt, IFG);
    p_grant = s_grant;
    p_valid = bus.tx_valid;
    p_busy  = bus.busy;
  endtask

  task automatic cycle();
    @(negedge aclk);
    sample();
    if (mon_en) monitor();
    @(posedge aclk);
    #1;
    driver();
  endtask

  task automatic reset_mon();
    p_grant = 3'b000; p_valid = 1'b0; p_busy = 1'b0; have_cur = 1'b0;
    gcnt = 0; pcnt = 0; lowrun = 0; ifgcnt = 0;
  endtask

  task automatic flush();
    for (int s = 0; s < 3; s++) begin
      byte_q[s].delete(); len_q[s].delete();
      m_bytes[s].delete(); m_len[s].delete();
      bidx[s] = 0;
      drive_src(s, 1'b0, 8'h00, 1'b0);
    end
    exp_q.delete();
    fr_q.delete();
    pre_k = -1; fcs_k = -1;
    s_grant = 3'b000; s_pe = 1'b0; s_abort = 1'b0; s_fdone = 1'b0;
    m_ptr = 2;
  endtask

  function automatic bit all_idle();
    return (len_q[0].size() + len_q[1].size() + len_q[2].size() == 0) && !bus.busy
           && exp_q.size() == 0 && fr_q.size() == 0;
  endfunction

  task automatic run_phase();
    int n;
    build_model();
    n = 0;
    while (n < LIMIT && !all_idle()) begin
      cycle();
      n++;
    end
    check("phase_timeout", n >= LIMIT, 0);
    repeat (3) cycle();
    check("exp_left", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n, cnt;
    fcs_tab[0] = 8'hAA; fcs_tab[1] = 8'hBB; fcs_tab[2] = 8'hCC; fcs_tab[3] = 8'hDD;
    flush();
    bus.preamble_data = 8'h00; bus.preamble_sfd_tx_done = 1'b0;
    bus.fcs_data = 8'h00; bus.fcs_tx_done = 1'b0;
    reset_mon();
    aresetn = 1'b0;
    repeat (3) cycle();
    check("rst_grant", {bus.udp_grant, bus.icmp_grant, bus.arp_grant}, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pstart", bus.preamble_start, 0);
    check("rst_payload_en", bus.payload_en, 0);
    check("rst_tx_abort", bus.tx_abort, 0);
    aresetn = 1'b1;
    mon_en = 1'b1;

    // all three requesting from reset: ARP, ICMP, UDP
    for (int s = 0; s < 3; s++) add_frame(s, $urandom_range(1, 40), 1'b0);
    run_phase();
    // directed byte-mux frame
    add_frame(0, 28, 1'b1);
    run_phase();
    // ICMP alone, then ARP+UDP together
    add_frame(1, $urandom_range(1, 40), 1'b0);
    run_phase();
    add_frame(0, $urandom_range(1, 40), 1'b0);
    add_frame(2, $urandom_range(1, 40), 1'b0);
    run_phase();
    // watchdog abort plus a frame of exactly MAXP bytes
    add_frame(2, 100, 1'b0);
    add_frame(0, MAXP, 1'b0);
    add_frame(1, $urandom_range(1, 40), 1'b0);
    run_phase();

    // reset in the middle of a payload
    add_frame(0, 30, 1'b0);
    build_model();
    n = 0;
    while (n < 200 && !bus.payload_en) begin cycle(); n++; end
    check("rst_wait_payload", n >= 200, 0);
    repeat (5) cycle();
    mon_en = 1'b0;
    aresetn = 1'b0;
    cycle();
    flush();
    aresetn = 1'b1;
    @(negedge aclk);
    sample();
    check("midrst_grant", s_grant, 0);
    check("midrst_tx_valid", bus.tx_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_tx_abort", bus.tx_abort, 0);
    @(posedge aclk);
    #1;
    driver();
    reset_mon();
    mon_en = 1'b1;
    add_frame(1, $urandom_range(1, 40), 1'b0);
    add_frame(0, $urandom_range(1, 40), 1'b0);
    run_phase();

    // randomized phases
    for (int ph = 0; ph < 15; ph++) begin
      cnt = 0;
      for (int s = 0; s < 3; s++) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          if ($urandom_range(0, 7) == 0) add_frame(s, $urandom_range(MAXP + 1, MAXP + 20), 1'b0);
          else add_frame(s, $urandom_range(1, 48), 1'b0);
          cnt++;
        end
      end
      if (cnt == 0) add_frame($urandom_range(0, 2), $urandom_range(1, 48), 1'b0);
      run_phase();
      repeat ($urandom_range(0, 5)) cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Frame-level TX controller for the Ethernet transmit path.
- Arbitrates between the three payload sources (ARP, ICMP, UDP) with a round-robin policy.
- Sequences each frame in order: preamble/SFD generator, granted payload source, FCS generator, inter-frame gap.
- Drives the byte mux onto the MAC TX byte stream and the payload byte stream into the FCS generator.

Parameters:
- IFG_CYCLES, 12, idle byte-cycles inserted after each FCS (min 1).
- MAX_PAYLOAD, 1518, watchdog limit on PAYLOAD cycles before abort.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- arp_req / icmp_req / udp_req  in  1 each  level request; held until the matching grant
- arp_grant / icmp_grant / udp_grant  out  1 each  one-hot registered grant
- arp_data / icmp_data / udp_data  in  8 each  source payload byte
- arp_data_done / icmp_data_done / udp_data_done  in  1 each  high with the source's last byte
- payload_en  out  1  high in PAYLOAD; granted source advances one byte per cycle while high
- preamble_start  out  1  one-cycle start pulse to the preamble/SFD generator
- preamble_data  in  8  preamble/SFD byte
- preamble_sfd_tx_done  in  1  high with the SFD byte
- fcs_payload_data  out  8  muxed payload byte to the FCS generator, 0 outside PAYLOAD
- fcs_payload_done  out  1  granted source's done, gated by payload_en
- fcs_data  in  8  FCS byte from the FCS generator
- fcs_tx_done  in  1  high with the 4th FCS byte
- tx_data  out  8  MAC TX byte
- tx_valid  out  1  byte valid
- tx_abort  out  1  one-cycle watchdog abort pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, aresetn low):
  - State IDLE; all grants, payload_en, preamble_start, tx_valid, tx_abort and busy are 0; tx_data = 0.
  - Round-robin pointer = UDP, so ARP wins first.
  - Counters cleared.
  - Reset mid-frame drops the frame immediately with no abort pulse.
- FSM states: IDLE, PREAMBLE, PAYLOAD, FCS, IFG.
  - IDLE: if any req is high, the arbiter picks a winner. Next cycle: state PREAMBLE, winner's grant = 1, preamble_start = 1 for that single cycle.
  - PREAMBLE: tx_data = preamble_data, tx_valid = 1. On preamble_sfd_tx_done go to PAYLOAD.
  - PAYLOAD:
    - payload_en = 1.
    - tx_data = fcs_payload_data = granted source byte; tx_valid = 1.
    - When the granted done is high, that byte is the last one; go to FCS next cycle. Grant drops on entering FCS.
  - FCS: tx_data = fcs_data, tx_valid = 1. On fcs_tx_done go to IFG.
  - IFG: tx_valid = 0, tx_data = 0. Count IFG_CYCLES cycles, then go to IDLE.
- Frame latency:
  - Arbitration takes 1 cycle in IDLE.
  - Back-to-back frames are separated by exactly IFG_CYCLES + 1 idle cycles: IFG_CYCLES in IFG plus 1 for arbitration.
- Round-robin arbitration:
  - Search order starts after the last winner: ARP -> ICMP -> UDP -> ARP.
  - The pointer updates to the winner at grant time.
  - Requests are sampled only in IDLE; changes in other states are ignored.
  - A request withdrawn in IDLE before grant is simply not served.
- Grant rules: grants are always one-hot or zero. Non-granted done signals and data are ignored.
- Watchdog:
  - 16-bit counter of PAYLOAD cycles.
  - If it reaches MAX_PAYLOAD without done: tx_abort = 1 for one cycle, grant dropped, go to IFG.
  - FCS is skipped; the FCS generator is left to its own reset/resync.
  - The pointer still advances.
- Done and preamble_sfd_tx_done in the same cycle cannot occur: done is only honoured in PAYLOAD.

Decomposition:
- Package eth_tx_pkg:
  - state_type enum (IDLE, PREAMBLE, PAYLOAD, FCS, IFG).
  - src_type enum (SRC_ARP, SRC_ICMP, SRC_UDP).
  - Default IFG_CYCLES and MAX_PAYLOAD localparams.
- Sub-module rr_arbiter3:
  - Combinational 3-way round-robin pick from req[2:0] and the last-winner pointer.
  - Outputs a one-hot winner and a valid flag.
  - Pointer register stays in eth_tx_scheduler.

Test Plan:
- ARP request only; preamble done after 8 cycles; 28 payload bytes; fcs_tx_done 4 cycles later -> arp_grant high 36 cycles (8 + 28), tx_valid high 40 cycles (8 + 28 + 4), then 12 idle cycles, busy low after.
- ARP, ICMP and UDP requests all held from reset -> grants served in order ARP, ICMP, UDP; consecutive tx_valid bursts separated by exactly 13 low cycles.
- After an ICMP frame, ARP and UDP request together -> UDP granted first, then ARP.
- Payload done never asserted with MAX_PAYLOAD = 64 -> tx_abort pulses on payload cycle 64, no FCS bytes, IFG entered, next request served normally.
- aresetn low for 1 cycle mid-PAYLOAD -> next cycle all grants 0, tx_valid 0, busy 0; the next frame goes to ARP.
- Byte mux check: preamble 0x55 x7 then 0xD5; payload 0x01..0x1C; FCS bytes 0xAA 0xBB 0xCC 0xDD -> tx_data carries exactly this sequence; fcs_payload_data is non-zero only during PAYLOAD.
